conditionare_buton: RTL

- Conditions one raw push-button input (BTN from the board) into clean control signals for the stopwatch counters and display path.
- Sits directly upstream of the numarator chain, and its outputs drive that chain's pause and reset inputs.
- Behaviour: 2-flop synchroniser, debounce FSM, one-cycle press pulse, pause toggle level and long-press pulse (used as the counters' clear).
- Runs on the board clock, ahead of the clock divider.

---
 rtl/conditionare_buton_pkg.sv | 12 +
 rtl/conditionare_buton_sincronizator_2ff.sv | 18 +
 rtl/conditionare_buton.sv | 86 ++++++++
 3 files changed

// File: rtl/conditionare_buton_pkg.sv
// conditionare_buton_pkg: shared state encoding and default timing constants for the button conditioner.
package conditionare_buton_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;
  localparam logic [15:0] DEF_DEBOUNCE_CYCLES   = 16'd50000;
  localparam logic [27:0] DEF_LONG_PRESS_CYCLES = 28'd100000000;
  localparam int          DEF_CNT_W             = 28;
endpackage

// File: rtl/conditionare_buton_sincronizator_2ff.sv
// sincronizator_2ff: two-flop synchroniser for an asynchronous level, cleared by active-low sync reset.
module sincronizator_2ff (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/conditionare_buton.sv
// conditionare_buton: debounces a raw button into level, press pulse, pause toggle and long-press pulse.
// Long-press detection is present only when CONDITIONARE_LONG_PRESS_EN is defined.
module conditionare_buton
  import conditionare_buton_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter logic [27:0] LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int          CNT_W             = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic pause,
  output logic long_press
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  if (DEBOUNCE_CYCLES < 16'd2 || LONG_PRESS_CYCLES < 28'd2) begin : g_bad_param
    $error("conditionare_buton: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 2");
  end
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_sync;
  logic             accept;
  sincronizator_2ff u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (btn_raw),
    .q      (btn_sync)
  );
  assign accept = state == PRESS_WAIT && btn_sync && cnt == DEB_LAST;
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
      pause     <= 1'b0;
    end else begin
      btn_press <= 1'b0;
      case (state)
        IDLE: if (btn_sync) begin
          state <= PRESS_WAIT;
          cnt   <= '0;
        end
        PRESS_WAIT: if (!btn_sync) state <= IDLE;
          else if (!accept) cnt <= cnt + CNT_W'(1);
          else begin
            state     <= PRESSED;
            btn_press <= 1'b1;
            pause     <= ~pause;
            btn_level <= 1'b1;
          end
        PRESSED: if (!btn_sync) begin
          state <= RELEASE_WAIT;
          cnt   <= '0;
        end
        RELEASE_WAIT: if (btn_sync) state <= PRESSED;
          else if (cnt != DEB_LAST) cnt <= cnt + CNT_W'(1);
          else begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end
      endcase
    end
  end
`ifdef CONDITIONARE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 28'd1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  logic [CNT_W-1:0] hold_cnt;
  // hold_cnt survives release glitches; it restarts only on a fresh acceptance
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= state == PRESSED && btn_sync && hold_cnt == HOLD_LAST;
      if (accept) hold_cnt <= '0;
      else if (state == PRESSED && btn_sync && hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule
